burst_ram_responder: RTL and testbench

Block-RAM stand-in for the SDRAM burst controller's host port. It answers the cache's line fill (`rd`) and spill (`wr`) requests with 8-beat, 16-bit bursts on the same `ready` / `burst_offset` / `hDOut` / `hDIn` handshake the cache already drives. This lets the 512-byte direct-mapped cache and the parasite CPU run without SDRAM, for bring-up and regression. It sits where the SDRAM controller's host side sits; the VGA port is not provided.

---
 rtl/burst_ram_responder.sv | 202 ++++++++++++++++++++
 tb/tb_burst_ram_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_responder.sv
// Block-RAM stand-in for the SDRAM controller host port: answers 8-beat line
// fill (rd) and spill (wr) bursts, with a one-entry pending request slot.
module burst_ram_responder #(
  parameter int HADDR_WIDTH  = 24,
  parameter int DATA_WIDTH   = 16,
  parameter int LINE_BITS    = 6,
  parameter int READ_LATENCY = 3
) (
  input  logic                   clk1x,
  input  logic                   reset,
  input  logic                   rd,
  input  logic                   wr,
  input  logic [HADDR_WIDTH-1:0] hAddr,
  input  logic [DATA_WIDTH-1:0]  hDIn,
  output logic [DATA_WIDTH-1:0]  hDOut,
  output logic                   ready,
  output logic                   writing,
  output logic [2:0]             burst_offset,
  output logic                   collision,
  output logic                   busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_WAIT  = 3'd1;
  localparam logic [2:0] RD_BURST = 3'd2;
  localparam logic [2:0] WR_BURST = 3'd3;
  localparam logic [2:0] WR_TAIL  = 3'd4;

  localparam int         MEM_AW    = LINE_BITS + 3;
  localparam int         MEM_DEPTH = 1 << MEM_AW;
  localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY - 1);

  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  logic [2:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           off_q, off_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic                 pend_valid_q, pend_valid_d;
  logic                 pend_wr_q, pend_wr_d;
  logic [LINE_BITS-1:0] pend_line_q, pend_line_d;
  logic                 collision_q, collision_d;
  logic [DATA_WIDTH-1:0] hdout_q;

  logic                 mem_we;
  logic [MEM_AW-1:0]    mem_waddr;
  logic [MEM_AW-1:0]    mem_raddr;
  logic                 fwd_hit;
  logic                 op_done;
  logic                 free;
  logic                 start;
  logic                 start_wr;
  logic [LINE_BITS-1:0] start_line;
  logic [LINE_BITS-1:0] req_line;
  logic                 unused_addr_bits;

  assign req_line         = hAddr[LINE_BITS+3:4];
  assign unused_addr_bits = ^{hAddr[HADDR_WIDTH-1:LINE_BITS+4], hAddr[3:0]};

  // The last cycle of a burst behaves like IDLE so the next request starts
  // without a bubble.
  assign op_done = ((state_q == RD_BURST) && (off_q == 3'd7)) || (state_q == WR_TAIL);
  assign free    = (state_q == IDLE) || op_done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    line_d       = line_q;
    pend_valid_d = pend_valid_q;
    pend_wr_d    = pend_wr_q;
    pend_line_d  = pend_line_q;
    collision_d  = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = {line_q, 3'(off_q - 3'd1)};
    start        = 1'b0;
    start_wr     = 1'b0;
    start_line   = req_line;

    case (state_q)
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RD_BURST;
          off_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_BURST: begin
        if (off_q == 3'd7) begin
          state_d = IDLE;
          off_d   = 3'd0;
        end else begin
          off_d = off_q + 3'd1;
        end
      end
      WR_BURST: begin
        // hDIn lags the presented offset by one cycle
        mem_we = (off_q != 3'd0);
        if (off_q == 3'd7) begin
          state_d = WR_TAIL;
        end else begin
          off_d = off_q + 3'd1;
        end
      end
      WR_TAIL: begin
        mem_we    = 1'b1;
        mem_waddr = {line_q, 3'd7};
        state_d   = IDLE;
        off_d     = 3'd0;
      end
      default: begin
        state_d = IDLE;
        off_d   = 3'd0;
      end
    endcase

    if (free) begin
      if (pend_valid_q) begin
        start        = 1'b1;
        start_wr     = pend_wr_q;
        start_line   = pend_line_q;
        pend_valid_d = 1'b0;
        collision_d  = rd | wr;
      end else if (rd | wr) begin
        start       = 1'b1;
        start_wr    = wr;
        collision_d = rd & wr;
      end
    end else if (rd | wr) begin
      if (pend_valid_q) begin
        collision_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_wr_d    = wr;
        pend_line_d  = req_line;
        collision_d  = rd & wr;
      end
    end

    if (start) begin
      line_d = start_line;
      off_d  = 3'd0;
      if (start_wr) begin
        state_d = WR_BURST;
      end else begin
        state_d = RD_WAIT;
        cnt_d   = WAIT_INIT;
      end
    end
  end

  // Prefetch the beat that will be presented next cycle.
  assign mem_raddr = {line_d, off_d};
  assign fwd_hit   = mem_we && (mem_waddr == mem_raddr);

  always_ff @(posedge clk1x) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      off_q        <= 3'd0;
      line_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_line_q  <= '0;
      collision_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      line_q       <= line_d;
      pend_valid_q <= pend_valid_d;
      pend_wr_q    <= pend_wr_d;
      pend_line_q  <= pend_line_d;
      collision_q  <= collision_d;
    end
  end

  always_ff @(posedge clk1x) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= hDIn;
    end
  end

  always_ff @(posedge clk1x) begin
    if (reset) begin
      hdout_q <= '0;
    end else if (fwd_hit) begin
      hdout_q <= hDIn;
    end else begin
      hdout_q <= mem[mem_raddr];
    end
  end

  assign hDOut        = hdout_q;
  assign ready        = (state_q == RD_BURST);
  assign writing      = (state_q == WR_BURST);
  assign burst_offset = off_q;
  assign collision    = collision_q;
  assign busy         = (state_q != IDLE) || pend_valid_q;

endmodule

// File: tb/tb_burst_ram_responder.sv
// Directed bench for burst_ram_responder: a cycle table for write-then-read,
// plus hand sequences for pending, collision, aliasing, reset and latency.
module tb_burst_ram_responder;

  logic        clk1x = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [23:0] hAddr = '0;
  logic [15:0] hDIn = '0;
  logic [15:0] hDOut;
  logic        ready, writing, collision, busy;
  logic [2:0]  burst_offset;

  logic        rd_l1 = 1'b0;
  logic        rd_l15 = 1'b0;
  logic        wr_idle = 1'b0;
  logic [15:0] hdout_l1, hdout_l15;
  logic        ready_l1, writing_l1, collision_l1, busy_l1;
  logic        ready_l15, writing_l15, collision_l15, busy_l15;
  logic [2:0]  off_l1, off_l15;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk1x = ~clk1x;

  burst_ram_responder #(.READ_LATENCY(3)) dut (
    .clk1x(clk1x), .reset(reset), .rd(rd), .wr(wr), .hAddr(hAddr), .hDIn(hDIn),
    .hDOut(hDOut), .ready(ready), .writing(writing), .burst_offset(burst_offset),
    .collision(collision), .busy(busy)
  );

  burst_ram_responder #(.READ_LATENCY(1)) dut_l1 (
    .clk1x(clk1x), .reset(reset), .rd(rd_l1), .wr(wr_idle), .hAddr(hAddr), .hDIn(hDIn),
    .hDOut(hdout_l1), .ready(ready_l1), .writing(writing_l1), .burst_offset(off_l1),
    .collision(collision_l1), .busy(busy_l1)
  );

  burst_ram_responder #(.READ_LATENCY(15)) dut_l15 (
    .clk1x(clk1x), .reset(reset), .rd(rd_l15), .wr(wr_idle), .hAddr(hAddr), .hDIn(hDIn),
    .hDOut(hdout_l15), .ready(ready_l15), .writing(writing_l15), .burst_offset(off_l15),
    .collision(collision_l15), .busy(busy_l15)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [23:0] addr;
    logic [15:0] din;
    logic        exp_ready;
    logic        exp_writing;
    logic [2:0]  exp_off;
    logic        chk_dout;
    logic [15:0] exp_dout;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1x);
    #1;
  endtask

  task automatic write_start(input logic [23:0] addr, input logic also_rd);
    $display("write line 0x%06h%s", addr, also_rd ? " (with rd)" : "");
    rd = also_rd;
    wr = 1'b1;
    hAddr = addr;
    step();
    rd = 1'b0;
    wr = 1'b0;
    check("wr start writing", 32'(writing), 32'd1);
    check("wr start offset", 32'(burst_offset), 32'd0);
    check("wr start collision", 32'(collision), 32'(also_rd));
  endtask

  task automatic write_body(input logic [15:0] base, input logic tail_rd, input logic [23:0] tail_addr);
    for (int s = 1; s <= 9; s++) begin
      hDIn = (s >= 2) ? base + 16'(s - 2) : 16'h0;
      if (s == 9 && tail_rd) begin
        rd = 1'b1;
        hAddr = tail_addr;
      end
      step();
      rd = 1'b0;
      if (s <= 7) begin
        check($sformatf("wr beat %0d writing", s), 32'(writing), 32'd1);
        check($sformatf("wr beat %0d offset", s), 32'(burst_offset), 32'(s));
        check($sformatf("wr beat %0d collision", s), 32'(collision), 32'd0);
      end else if (s == 8) begin
        check("wr tail writing", 32'(writing), 32'd0);
        check("wr tail offset", 32'(burst_offset), 32'd7);
        check("wr tail busy", 32'(busy), 32'd1);
      end else begin
        check("wr end offset", 32'(burst_offset), 32'd0);
        check("wr end busy", 32'(busy), 32'(tail_rd));
        check("wr end collision", 32'(collision), 32'd0);
        check("wr end ready", 32'(ready), 32'd0);
      end
    end
    hDIn = 16'h0;
  endtask

  task automatic read_wait(input int exp_wait, input logic [15:0] base);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("read latency", 32'(n), 32'(exp_wait));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rd beat %0d ready", k), 32'(ready), 32'd1);
      check($sformatf("rd beat %0d offset", k), 32'(burst_offset), 32'(k));
      check($sformatf("rd beat %0d data", k), 32'(hDOut), 32'(base + 16'(k)));
      step();
    end
    check("rd end ready", 32'(ready), 32'd0);
    check("rd end offset", 32'(burst_offset), 32'd0);
  endtask

  task automatic read_line(input logic [23:0] addr, input logic [15:0] base);
    $display("read line 0x%06h expecting 0x%04h..", addr, base);
    rd = 1'b1;
    hAddr = addr;
    step();
    rd = 1'b0;
    check("rd accept busy", 32'(busy), 32'd1);
    read_wait(3, base);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nr;
    int first1;
    int first15;

    for (int i = 0; i < 22; i++) begin
      vecs[i] = '{rd: 1'b0, wr: 1'b0, addr: 24'h000120, din: 16'h0,
                  exp_ready: 1'b0, exp_writing: 1'b0, exp_off: 3'd0,
                  chk_dout: 1'b0, exp_dout: 16'h0, exp_busy: 1'b0};
      if (i <= 7) begin
        vecs[i].exp_writing = 1'b1;
        vecs[i].exp_off = 3'(i);
        vecs[i].exp_busy = 1'b1;
      end
      if (i == 8) begin
        vecs[i].exp_off = 3'd7;
        vecs[i].exp_busy = 1'b1;
      end
      if (i >= 2 && i <= 9) vecs[i].din = 16'h1000 + 16'(i - 2);
      if (i >= 10 && i <= 12) vecs[i].exp_busy = 1'b1;
      if (i >= 13 && i <= 20) begin
        vecs[i].exp_ready = 1'b1;
        vecs[i].exp_off = 3'(i - 13);
        vecs[i].chk_dout = 1'b1;
        vecs[i].exp_dout = 16'h1000 + 16'(i - 13);
        vecs[i].exp_busy = 1'b1;
      end
    end
    vecs[0].wr = 1'b1;
    vecs[10].rd = 1'b1;

    step();
    step();
    check("reset ready", 32'(ready), 32'd0);
    check("reset writing", 32'(writing), 32'd0);
    check("reset offset", 32'(burst_offset), 32'd0);
    check("reset collision", 32'(collision), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset hDOut", 32'(hDOut), 32'd0);
    reset = 1'b0;

    $display("table: write then read line 0x000120");
    for (int i = 0; i < 22; i++) begin
      rd = vecs[i].rd;
      wr = vecs[i].wr;
      hAddr = vecs[i].addr;
      hDIn = vecs[i].din;
      step();
      check($sformatf("vec %0d ready", i), 32'(ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec %0d writing", i), 32'(writing), 32'(vecs[i].exp_writing));
      check($sformatf("vec %0d offset", i), 32'(burst_offset), 32'(vecs[i].exp_off));
      check($sformatf("vec %0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec %0d collision", i), 32'(collision), 32'd0);
      if (vecs[i].chk_dout)
        check($sformatf("vec %0d hDOut", i), 32'(hDOut), 32'(vecs[i].exp_dout));
    end
    rd = 1'b0;
    wr = 1'b0;
    hDIn = 16'h0;

    write_start(24'h000400, 1'b0);
    write_body(16'h5000, 1'b0, 24'h0);

    $display("spill 0x000200 then fill 0x000400 during tail");
    write_start(24'h000200, 1'b0);
    write_body(16'h2000, 1'b1, 24'h000400);
    read_wait(3, 16'h5000);

    $display("spill 0x000600 then fill same line during tail");
    write_start(24'h000600, 1'b0);
    write_body(16'h6000, 1'b1, 24'h000600);
    read_wait(3, 16'h6000);

    write_start(24'h000300, 1'b1);
    write_body(16'h7000, 1'b0, 24'h0);

    $display("three requests during read of 0x000120");
    rd = 1'b1;
    hAddr = 24'h000120;
    step();
    rd = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("3req latency", 32'(n), 32'd3);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("3req beat %0d offset", k), 32'(burst_offset), 32'(k));
      check($sformatf("3req beat %0d data", k), 32'(hDOut), 32'(16'h1000 + 16'(k)));
      check($sformatf("3req beat %0d collision", k), 32'(collision), 32'(k == 5));
      if (k == 2) begin
        wr = 1'b1;
        hAddr = 24'h000500;
      end
      if (k == 4) begin
        rd = 1'b1;
        hAddr = 24'h000120;
      end
      step();
      rd = 1'b0;
      wr = 1'b0;
    end
    check("3req pending wr writing", 32'(writing), 32'd1);
    check("3req pending wr offset", 32'(burst_offset), 32'd0);
    check("3req pending wr ready", 32'(ready), 32'd0);
    write_body(16'h3000, 1'b0, 24'h0);
    nr = 0;
    for (int c = 0; c < 20; c++) begin
      if (ready === 1'b1) nr++;
      step();
    end
    check("3req dropped read beats", 32'(nr), 32'd0);
    read_line(24'h000500, 16'h3000);

    write_start(24'h000010, 1'b0);
    write_body(16'h4000, 1'b0, 24'h0);
    read_line(24'h004010, 16'h4000);

    $display("reset during read beat 3 of 0x000120");
    rd = 1'b1;
    hAddr = 24'h000120;
    step();
    rd = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    step();
    step();
    step();
    check("pre-reset offset", 32'(burst_offset), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid reset ready", 32'(ready), 32'd0);
    check("mid reset offset", 32'(burst_offset), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset hDOut", 32'(hDOut), 32'd0);
    read_line(24'h000120, 16'h1000);

    $display("latency sweep READ_LATENCY=1 and 15");
    rd_l1 = 1'b1;
    rd_l15 = 1'b1;
    hAddr = 24'h000120;
    step();
    rd_l1 = 1'b0;
    rd_l15 = 1'b0;
    first1 = -1;
    first15 = -1;
    for (int c = 0; c < 40; c++) begin
      if (ready_l1 === 1'b1 && first1 < 0) first1 = c;
      if (ready_l15 === 1'b1 && first15 < 0) first15 = c;
      step();
    end
    check("latency RL=1 cycles after rd", 32'(first1 + 1), 32'd2);
    check("latency RL=15 cycles after rd", 32'(first15 + 1), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
